// File: rtl/config_readback.sv
// Configuration readback engine: walks every config frame through a shadow
// register and streams it as words with a sync header and XOR checksum.
module config_readback #(
  parameter int NUM_FRAMES = 172,
  parameter int FRAME_W    = 320,
  parameter int WORD_W     = 16
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  start_i,
  input  logic                  abort_i,
  output logic [NUM_FRAMES-1:0] rd_frame_sel_o,
  input  logic [FRAME_W-1:0]    rd_frame_data_i,
  output logic                  freeze_o,
  output logic [WORD_W-1:0]     dout_o,
  output logic                  dout_valid_o,
  input  logic                  dout_ready_i,
  output logic                  busy_o,
  output logic                  done_o
);

  localparam int WPF = FRAME_W / WORD_W;
  localparam int FCW = (NUM_FRAMES > 1) ? $clog2(NUM_FRAMES) : 1;
  localparam int WCW = (WPF > 1) ? $clog2(WPF) : 1;
  localparam logic [WORD_W-1:0] SYNC_WORD = WORD_W'(16'hC0F6);
  localparam logic [FCW-1:0] LAST_FRAME = FCW'(NUM_FRAMES - 1);
  localparam logic [WCW-1:0] LAST_WORD  = WCW'(WPF - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_SYNC, S_SELECT, S_CAPTURE, S_SEND, S_CKSUM, S_DONE
  } state_e;

  state_e                       state_q, state_d;
  logic [FCW-1:0]               frame_q, frame_d;
  logic [WCW-1:0]               word_q, word_d;
  logic                         wait_q, wait_d;
  logic [WPF-1:0][WORD_W-1:0]   shadow_q, shadow_d;
  logic [WORD_W-1:0]            cksum_q, cksum_d;
  logic [WORD_W-1:0]            cur_word;
  logic                         sel_active;
  logic                         xfer;

  assign cur_word = shadow_q[word_q];
  assign xfer     = dout_valid_o & dout_ready_i;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q  <= S_IDLE;
      frame_q  <= '0;
      word_q   <= '0;
      wait_q   <= 1'b0;
      shadow_q <= '0;
      cksum_q  <= '0;
    end else begin
      state_q  <= state_d;
      frame_q  <= frame_d;
      word_q   <= word_d;
      wait_q   <= wait_d;
      shadow_q <= shadow_d;
      cksum_q  <= cksum_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    frame_d  = frame_q;
    word_d   = word_q;
    wait_d   = wait_q;
    shadow_d = shadow_q;
    cksum_d  = cksum_q;
    case (state_q)
      S_IDLE: begin
        if (start_i) begin
          state_d = S_SYNC;
          frame_d = '0;
          word_d  = '0;
          wait_d  = 1'b0;
          cksum_d = '0;
        end
      end
      S_SYNC: begin
        if (xfer) begin
          state_d = S_SELECT;
          frame_d = '0;
          wait_d  = 1'b0;
        end
      end
      // Two select cycles cover the fabric's read latency before capture.
      S_SELECT: begin
        if (wait_q) begin
          state_d = S_CAPTURE;
          wait_d  = 1'b0;
        end else begin
          wait_d = 1'b1;
        end
      end
      S_CAPTURE: begin
        shadow_d = rd_frame_data_i;
        word_d   = '0;
        state_d  = S_SEND;
      end
      S_SEND: begin
        if (xfer) begin
          cksum_d = cksum_q ^ cur_word;
          if (word_q == LAST_WORD) begin
            word_d = '0;
            if (frame_q == LAST_FRAME) begin
              state_d = S_CKSUM;
            end else begin
              frame_d = frame_q + 1'b1;
              wait_d  = 1'b0;
              state_d = S_SELECT;
            end
          end else begin
            word_d = word_q + 1'b1;
          end
        end
      end
      S_CKSUM: begin
        if (xfer) state_d = S_DONE;
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    if (abort_i && (state_q != S_IDLE)) begin
      state_d = S_IDLE;
      frame_d = '0;
      word_d  = '0;
      wait_d  = 1'b0;
    end
  end

  always_comb begin
    busy_o       = (state_q != S_IDLE);
    freeze_o     = busy_o;
    done_o       = (state_q == S_DONE);
    sel_active   = (state_q == S_SELECT) || (state_q == S_CAPTURE) || (state_q == S_SEND);
    dout_o       = '0;
    dout_valid_o = 1'b0;
    case (state_q)
      S_SYNC: begin
        dout_o       = SYNC_WORD;
        dout_valid_o = 1'b1;
      end
      S_SEND: begin
        dout_o       = cur_word;
        dout_valid_o = 1'b1;
      end
      S_CKSUM: begin
        dout_o       = cksum_q;
        dout_valid_o = 1'b1;
      end
      default: ;
    endcase
  end

  for (genvar gi = 0; gi < NUM_FRAMES; gi++) begin : g_sel
    assign rd_frame_sel_o[gi] = sel_active && (frame_q == FCW'(gi));
  end

endmodule

// File: tb/tb_config_readback.sv
// Bench for config_readback: fabric model with 2-cycle read latency, stream
// scoreboard built from frame contents, plus abort/reset/backpressure cases.
module tb_config_readback;
  localparam int NF    = 172;
  localparam int FRW   = 320;
  localparam int WW    = 16;
  localparam int WPF   = 20;
  localparam int TOTAL = 1 + NF * WPF + 1;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic            rst_ni, start_i, abort_i, dout_ready_i;
  logic [NF-1:0]   sel;
  logic [FRW-1:0]  fab_data;
  logic            freeze, busy, done, dout_valid;
  logic [WW-1:0]   dout;

  config_readback #(.NUM_FRAMES(NF), .FRAME_W(FRW), .WORD_W(WW)) dut (
    .clk_i(clk), .rst_ni(rst_ni), .start_i(start_i), .abort_i(abort_i),
    .rd_frame_sel_o(sel), .rd_frame_data_i(fab_data), .freeze_o(freeze),
    .dout_o(dout), .dout_valid_o(dout_valid), .dout_ready_i(dout_ready_i),
    .busy_o(busy), .done_o(done)
  );

  int n_assert = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int mode     = 0;
  logic [15:0] rmem [NF][WPF];
  logic [NF-1:0] sel_d1 = '0, sel_d2 = '0;

  logic [15:0] got[$];
  int          got_cyc[$];
  int          done_count = 0, done_cyc = 0, last_xfer = 0, start_cyc = 0;
  int          drop_at = -1, hold = 0, busy_start_at = -1;
  bit          rnd_ready = 0;

  function automatic logic [15:0] word_of(int k, int w);
    case (mode)
      0:       return 16'(k);
      1:       return (k == 5 && w == 3) ? 16'h1234 : 16'h0000;
      default: return rmem[k][w];
    endcase
  endfunction

  // Fabric: data reflects the select seen two edges earlier.
  always @(posedge clk) begin
    cyc    <= cyc + 1;
    sel_d1 <= sel;
    sel_d2 <= sel_d1;
  end

  always_comb begin
    fab_data = '0;
    for (int k = 0; k < NF; k++)
      if (sel_d2[k])
        for (int w = 0; w < WPF; w++) fab_data[w*WW +: WW] = word_of(k, w);
  end

  task automatic chk(input string tag, input logic [NF-1:0] obs, input logic [NF-1:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  logic        prev_hold = 1'b0;
  logic [15:0] prev_dout = '0;
  always @(negedge clk) begin
    logic [NF-1:0] esel;
    int i;
    if (rst_ni) begin
      chk("freeze_eq_busy", freeze, busy);
      if (!dout_valid) chk("dout_zero_when_invalid", dout, 0);
      if (prev_hold) begin
        chk("bp_valid_held", dout_valid, 1);
        chk("bp_dout_held", dout, prev_dout);
      end
      if (dout_valid && dout_ready_i && !abort_i) begin
        i = got.size();
        esel = '0;
        if (i >= 1 && i <= NF * WPF) esel[(i-1)/WPF] = 1'b1;
        chk("sel_during_xfer", sel, esel);
        got.push_back(dout);
        got_cyc.push_back(cyc);
        last_xfer = cyc;
      end
      if (done) begin
        done_count++;
        done_cyc = cyc;
      end
      prev_hold = dout_valid && !dout_ready_i && !abort_i;
      prev_dout = dout;
    end else begin
      prev_hold = 1'b0;
    end
  end

  function automatic void build_exp(ref logic [15:0] q[$]);
    logic [15:0] acc = '0;
    q.delete();
    q.push_back(16'hC0F6);
    for (int f = 0; f < NF; f++)
      for (int w = 0; w < WPF; w++) begin
        q.push_back(word_of(f, w));
        acc ^= word_of(f, w);
      end
    q.push_back(acc);
  endfunction

  task automatic start_run();
    got.delete();
    got_cyc.delete();
    done_count = 0;
    @(posedge clk); #1 start_i = 1'b1;
    @(posedge clk); #1 start_i = 1'b0;
    start_cyc = cyc;
  endtask

  task automatic pump(input int stop_at);
    int n = 0;
    while (done_count == 0 && got.size() != stop_at) begin
      if (n > 20000) begin
        chk("cycle_budget", 1, 0);
        break;
      end
      @(posedge clk); #1;
      n++;
      start_i = 1'b0;
      if (busy_start_at >= 0 && got.size() == busy_start_at) begin
        start_i = 1'b1;
        busy_start_at = -1;
      end
      if (hold > 0) begin
        dout_ready_i = 1'b0;
        hold--;
      end else if (drop_at >= 0 && got.size() == drop_at) begin
        dout_ready_i = 1'b0;
        hold = 6;
        drop_at = -1;
      end else begin
        dout_ready_i = rnd_ready ? ($urandom_range(3) != 0) : 1'b1;
      end
    end
    start_i = 1'b0;
  endtask

  task automatic check_full(input string tag);
    logic [15:0] exp[$];
    int n;
    build_exp(exp);
    chk({tag, "_length"}, got.size(), TOTAL);
    n = (got.size() < exp.size()) ? got.size() : exp.size();
    for (int i = 0; i < n; i++) chk($sformatf("%s_word%0d", tag, i), got[i], exp[i]);
    chk({tag, "_done_after_last"}, done_cyc, last_xfer + 1);
    repeat (3) @(posedge clk);
    #1;
    chk({tag, "_done_once"}, done_count, 1);
    chk({tag, "_idle_after"}, busy, 0);
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_sel"}, sel, 0);
    chk({tag, "_dout"}, dout, 0);
    chk({tag, "_valid"}, dout_valid, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_freeze"}, freeze, 0);
    chk({tag, "_done"}, done, 0);
  endtask

  initial begin
    logic [15:0] exp[$];
    rst_ni = 1'b0; start_i = 1'b0; abort_i = 1'b0; dout_ready_i = 1'b1;
    for (int k = 0; k < NF; k++)
      for (int w = 0; w < WPF; w++) rmem[k][w] = 16'($urandom);
    repeat (3) @(posedge clk);
    #1 chk_all_zero("reset");
    rst_ni = 1'b1;

    // Full readback, frame k = k in every word.
    mode = 0;
    start_run();
    pump(-1);
    chk("sync_at_start_edge", got_cyc[0], start_cyc);
    chk("first_frame_latency", got_cyc[1] - got_cyc[0], 4);
    chk("next_frame_latency", got_cyc[21] - got_cyc[20], 4);
    check_full("full");

    // Single non-zero word drives the checksum.
    mode = 1;
    start_run();
    pump(-1);
    chk("cksum_1234", got[got.size()-1], 16'h1234);
    check_full("cksum");

    // Seven-cycle ready drop in the middle of a frame.
    mode = 0;
    drop_at = 1005;
    start_run();
    pump(-1);
    check_full("bp");

    // Abort during frame 100 word 5, with start held high alongside.
    start_run();
    pump(1 + 100 * WPF + 5);
    chk("abort_pre_valid", dout_valid, 1);
    abort_i = 1'b1; start_i = 1'b1;
    @(posedge clk); #1;
    abort_i = 1'b0; start_i = 1'b0;
    chk("abort_busy", busy, 0);
    chk("abort_sel", sel, 0);
    chk("abort_freeze", freeze, 0);
    chk("abort_valid", dout_valid, 0);
    repeat (5) @(posedge clk);
    #1;
    chk("abort_no_done", done_count, 0);
    chk("abort_stays_idle", busy, 0);
    start_run();
    pump(-1);
    chk("restart_sync", got[0], 16'hC0F6);
    check_full("restart");

    // Start while busy at frame 10, then async reset during frame 40.
    busy_start_at = 1 + 10 * WPF + 3;
    start_run();
    pump(1 + 40 * WPF + 2);
    #1 rst_ni = 1'b0;
    #1 chk_all_zero("async_reset");
    repeat (2) @(posedge clk);
    #1 rst_ni = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    chk("post_reset_idle", busy, 0);
    chk("post_reset_no_done", done_count, 0);
    chk("post_reset_no_cksum", got.size(), 1 + 40 * WPF + 2);
    build_exp(exp);
    for (int i = 0; i < got.size(); i++) chk($sformatf("prefix_word%0d", i), got[i], exp[i]);

    // Random frame data with random backpressure.
    mode = 2;
    rnd_ready = 1'b1;
    start_run();
    pump(-1);
    rnd_ready = 1'b0;
    dout_ready_i = 1'b1;
    check_full("random");

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule

// File: doc/config_readback.md
CONFIG_READBACK -- requirements
Module: config_readback

Interface
REQ-001 The block SHALL have parameter NUM_FRAMES, default 172: number of configuration frames; one frame per configs_en bit.
REQ-002 The block SHALL have parameter FRAME_W, default 320: width of one configuration frame.
REQ-003 The block SHALL have parameter WORD_W, default 16: width of the output stream word. FRAME_W SHALL be an integer multiple of WORD_W, giving WPF = FRAME_W/WORD_W words per frame (20 by default).
REQ-004 clock  input  1  The single clock; all state updates on its rising edge.
REQ-005 rst  input  1  Reset; asynchronous and active-low.
REQ-006 start  input  1  Single-cycle request to begin a readback; sampled only in IDLE.
REQ-007 abort  input  1  Synchronous cancel of a readback in progress.
REQ-008 rd_frame_sel  output  NUM_FRAMES  One-hot frame select into the fabric config chain, with bit k selecting frame k.
REQ-009 rd_frame_data  input  FRAME_W  Frame contents returned by the fabric; valid 2 cycles after rd_frame_sel changes.
REQ-010 freeze  output  1  Held high while busy, so fabric flops are held and config is static during readback.
REQ-011 dout  output  WORD_W  Readback stream data.
REQ-012 dout_valid  output  1  dout holds a valid word.
REQ-013 dout_ready  input  1  The consumer accepts the word; a transfer occurs when dout_valid and dout_ready are both high.
REQ-014 busy  output  1  High in every state except IDLE.
REQ-015 done  output  1  One-cycle pulse after the checksum word is transferred.

Function
REQ-016 The FSM SHALL have the states IDLE, SYNC, SELECT, CAPTURE, SEND, CKSUM and DONE.
REQ-017 IDLE with start=1 SHALL go to SYNC on the next edge. In SYNC, dout=16'hC0F6 and dout_valid=1; on transfer the FSM goes to SELECT with frame index f=0.
REQ-018 SELECT SHALL drive rd_frame_sel = 1<<f and wait exactly 2 cycles, then go to CAPTURE.
REQ-019 CAPTURE SHALL register rd_frame_data into a FRAME_W shadow register in one cycle, set word index w=0, and go to SEND.
REQ-020 In SEND:
- dout SHALL be shadow[w*WORD_W +: WORD_W], with the LSB word first, and dout_valid=1.
- Each transfer SHALL increment w.
- The transfer with w=WPF-1 SHALL go to SELECT with f+1, or to CKSUM if f=NUM_FRAMES-1.
REQ-021 rd_frame_sel SHALL keep selecting frame f through CAPTURE and SEND, and SHALL be all-zero in IDLE, SYNC, CKSUM and DONE.
REQ-022 Checksum:
- The checksum SHALL be a WORD_W XOR accumulator, cleared on entry to SYNC.
- It SHALL XOR in every transferred frame word; the sync word is excluded.
- CKSUM SHALL present the accumulator with dout_valid=1; on transfer the FSM goes to DONE.
REQ-023 DONE SHALL assert done for exactly one cycle, then return to IDLE.
REQ-024 The default stream SHALL be 1 + 172*20 + 1 = 3442 words.
REQ-025 Backpressure: while dout_valid=1 and dout_ready=0, dout SHALL be held stable and no state, index or checksum SHALL change.
REQ-026 dout_valid SHALL be 0 in IDLE, SELECT, CAPTURE and DONE. dout SHALL be 0 whenever dout_valid=0.
REQ-027 start asserted while busy=1 SHALL be ignored.
REQ-028 abort=1 in any non-IDLE state SHALL force IDLE on the next edge:
- done is not pulsed;
- rd_frame_sel is zeroed;
- freeze drops.
abort has priority over start and over a simultaneous transfer.
REQ-029 freeze SHALL equal busy.
REQ-030 Frame and word counters SHALL be sized $clog2(NUM_FRAMES) and $clog2(WPF) bits. Frame wrap past NUM_FRAMES-1 SHALL NOT occur: the FSM leaves to CKSUM.
REQ-031 Timing from start:
- start sampled at edge 0 gives the SYNC word valid from edge 1.
- With dout_ready held at 1, the frame-0 word 0 is valid 4 cycles after the SYNC transfer.
- Each subsequent frame costs 3 non-transfer cycles.

Reset
REQ-032 rst=0 SHALL asynchronously force:
- state=IDLE;
- rd_frame_sel=0, dout=0, dout_valid=0, busy=0, freeze=0, done=0;
- counters=0 and checksum=0.
REQ-033 Reset asserted mid-readback SHALL abandon the stream without a checksum word. After release, the block SHALL wait in IDLE for a new start.

Verification
REQ-034 Full readback: fabric model returns frame k = {20{k[15:0]}}, dout_ready=1, pulse start.
- Expect 3442 words: 16'hC0F6 first, then 20 words of value k for each k=0..171.
- Expect a final checksum of 16'h0000 (each frame XORs 20 equal words).
- Expect done one cycle after the last transfer.
REQ-035 Checksum: frame 5, word 3 = 16'h1234; all other data is 0.
- Expect checksum word 16'h1234.
- Expect rd_frame_sel=1<<5 during frame 5's SEND.
REQ-036 Backpressure: drop dout_ready for 7 cycles mid-frame.
- Expect dout and dout_valid held constant.
- Expect the total word count still 3442 and the content identical to REQ-034.
REQ-037 abort during frame 100 SEND, with dout_valid=1 and dout_ready=1:
- Expect the next cycle busy=0, rd_frame_sel=0, no done.
- A following start restarts with 16'hC0F6.
REQ-038 Reset during frame 40: rst=0 asynchronously clears all outputs within the same cycle. start while busy (at frame 10) has no effect on the word sequence.
